// File: rtl/issue_scoreboard.sv
// Issue scoreboard and in-order commit buffer between decode, issue/read, FU write-back and commit.
// Tags entries on issue ack, captures write-backs, exports RAW forwarding state and retires in program order.
package issue_scoreboard_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned NR_ENTRIES    = 8;
  localparam int unsigned NR_WB_PORTS   = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            cf;
    logic [XLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [XLEN-1:0]          imm;
    logic [XLEN-1:0]          result;
    logic                     valid;
    logic                     use_imm;
    logic                     use_zimm;
    logic                     use_pc;
    exception_t               ex;
    branchpredict_sbe_t       bp;
    logic                     is_compressed;
  } scoreboard_entry_t;

  typedef struct packed {
    logic                     valid;
    logic                     ex_valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
  } wb_fwd_t;

  typedef struct packed {
    scoreboard_entry_t [NR_ENTRIES-1:0]  sbe;
    logic [NR_ENTRIES-1:0]               still_issued;
    logic [TRANS_ID_BITS-1:0]            issue_pointer;
    wb_fwd_t [NR_WB_PORTS-1:0]           wb;
  } forwarding_t;
endpackage

module issue_scoreboard #(
  parameter int unsigned NR_ENTRIES  = issue_scoreboard_pkg::NR_ENTRIES,
  parameter int unsigned NR_WB_PORTS = issue_scoreboard_pkg::NR_WB_PORTS,
  parameter type scoreboard_entry_t  = issue_scoreboard_pkg::scoreboard_entry_t,
  parameter type forwarding_t        = issue_scoreboard_pkg::forwarding_t
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_ni,
  input  logic                                                      flush_i,
  input  scoreboard_entry_t                                         decoded_instr_i,
  input  logic                                                      decoded_instr_valid_i,
  output logic                                                      decoded_instr_ack_o,
  output scoreboard_entry_t                                         issue_instr_o,
  output logic                                                      issue_instr_valid_o,
  input  logic                                                      issue_ack_i,
  output forwarding_t                                               fwd_o,
  input  logic [NR_WB_PORTS-1:0][$clog2(NR_ENTRIES)-1:0]            wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][issue_scoreboard_pkg::XLEN-1:0]    wb_data_i,
  input  logic [NR_WB_PORTS-1:0]                                    wb_ex_valid_i,
  input  logic [NR_WB_PORTS-1:0]                                    wb_valid_i,
  output scoreboard_entry_t                                         commit_instr_o,
  output logic                                                      commit_valid_o,
  input  logic                                                      commit_ack_i
);

  localparam int unsigned IDW = $clog2(NR_ENTRIES);
  localparam int unsigned CW  = IDW + 1;

  scoreboard_entry_t [NR_ENTRIES-1:0] mem_q, mem_d;
  logic [NR_ENTRIES-1:0]              issued_q, issued_d;
  logic [IDW-1:0]                     issue_ptr_q, commit_ptr_q;
  logic [CW-1:0]                      count_q;
  logic                               full, alloc, retire;

  // Full is taken from the registered count, so a same-cycle retire never frees a slot for issue.
  assign full = (count_q == CW'(NR_ENTRIES));

  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = issue_ptr_q;
  end

  assign issue_instr_valid_o = decoded_instr_valid_i & ~full & ~flush_i;
  assign decoded_instr_ack_o = issue_ack_i & issue_instr_valid_o;
  assign alloc               = decoded_instr_ack_o;

  assign commit_instr_o = mem_q[commit_ptr_q];
  assign commit_valid_o = issued_q[commit_ptr_q] & mem_q[commit_ptr_q].valid & ~flush_i;
  assign retire         = commit_ack_i & commit_valid_o;

  always_comb begin
    mem_d = mem_q;
    if (!flush_i) begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (wb_valid_i[k] && issued_q[wb_trans_id_i[k]]) begin
          mem_d[wb_trans_id_i[k]].valid  = 1'b1;
          mem_d[wb_trans_id_i[k]].result = wb_data_i[k];
          if (wb_ex_valid_i[k]) begin
            mem_d[wb_trans_id_i[k]].ex.valid = 1'b1;
            mem_d[wb_trans_id_i[k]].ex.tval  = wb_data_i[k];
          end
        end
      end
      // An instruction that already faulted in the front end needs no write-back to commit.
      if (alloc) begin
        mem_d[issue_ptr_q]       = issue_instr_o;
        mem_d[issue_ptr_q].valid = decoded_instr_i.ex.valid;
      end
    end
  end

  always_comb begin
    issued_d = issued_q;
    if (retire) issued_d[commit_ptr_q] = 1'b0;
    if (alloc)  issued_d[issue_ptr_q]  = 1'b1;
    if (flush_i) issued_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q        <= '0;
      issued_q     <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      mem_q    <= mem_d;
      issued_q <= issued_d;
      if (flush_i) begin
        issue_ptr_q  <= '0;
        commit_ptr_q <= '0;
        count_q      <= '0;
      end else begin
        if (alloc)  issue_ptr_q  <= issue_ptr_q + IDW'(1);
        if (retire) commit_ptr_q <= commit_ptr_q + IDW'(1);
        count_q <= count_q + CW'(alloc) - CW'(retire);
      end
    end
  end

  always_comb begin
    fwd_o               = '0;
    fwd_o.sbe           = mem_q;
    fwd_o.issue_pointer = issue_ptr_q;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      fwd_o.still_issued[i] = issued_q[i] & (mem_q[i].rd != '0);
    end
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      fwd_o.wb[k].valid    = wb_valid_i[k];
      fwd_o.wb[k].ex_valid = wb_ex_valid_i[k];
      fwd_o.wb[k].trans_id = wb_trans_id_i[k];
      fwd_o.wb[k].data     = wb_data_i[k];
    end
  end

  for (genvar a = 0; a < NR_WB_PORTS; a++) begin : g_wb_a
    for (genvar b = a + 1; b < NR_WB_PORTS; b++) begin : g_wb_b
      a_wb_unique_tag: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wb_valid_i[a] && wb_valid_i[b] && (wb_trans_id_i[a] == wb_trans_id_i[b])));
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios then random traffic against a program-order queue model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int NE  = NR_ENTRIES;
  localparam int NW  = NR_WB_PORTS;
  localparam int IDW = TRANS_ID_BITS;

  logic                         clk_i = 1'b0;
  logic                         rst_ni = 1'b0;
  logic                         flush_i;
  scoreboard_entry_t            decoded_instr_i, issue_instr_o, commit_instr_o;
  logic                         decoded_instr_valid_i, decoded_instr_ack_o;
  logic                         issue_instr_valid_o, issue_ack_i;
  logic                         commit_valid_o, commit_ack_i;
  forwarding_t                  fwd_o;
  logic [NW-1:0][IDW-1:0]       wb_trans_id_i;
  logic [NW-1:0][XLEN-1:0]      wb_data_i;
  logic [NW-1:0]                wb_ex_valid_i, wb_valid_i;

  int checks = 0;
  int failures = 0;

  // Model: in-flight entries in program order, plus the next tag to hand out.
  scoreboard_entry_t mq[$];
  int                mptr = 0;

  issue_scoreboard dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .decoded_instr_i(decoded_instr_i), .decoded_instr_valid_i(decoded_instr_valid_i),
    .decoded_instr_ack_o(decoded_instr_ack_o),
    .issue_instr_o(issue_instr_o), .issue_instr_valid_o(issue_instr_valid_o), .issue_ack_i(issue_ack_i),
    .fwd_o(fwd_o),
    .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i), .wb_ex_valid_i(wb_ex_valid_i), .wb_valid_i(wb_valid_i),
    .commit_instr_o(commit_instr_o), .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t rand_entry(input int ex_pct);
    logic [255:0]      r;
    scoreboard_entry_t e;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    e = r[$bits(scoreboard_entry_t)-1:0];
    e.ex.valid = (int'($urandom % 100) < ex_pct);
    return e;
  endfunction

  task automatic idle();
    flush_i               = 1'b0;
    decoded_instr_i       = '0;
    decoded_instr_valid_i = 1'b0;
    issue_ack_i           = 1'b0;
    commit_ack_i          = 1'b0;
    wb_trans_id_i         = '0;
    wb_data_i             = '0;
    wb_ex_valid_i         = '0;
    wb_valid_i            = '0;
  endtask

  task automatic offer(input scoreboard_entry_t e);
    decoded_instr_i       = e;
    decoded_instr_valid_i = 1'b1;
    issue_ack_i           = 1'b1;
  endtask

  task automatic put_wb(input int k, input int tag, input logic [XLEN-1:0] d, input logic ex);
    wb_valid_i[k]    = 1'b1;
    wb_trans_id_i[k] = IDW'(tag);
    wb_data_i[k]     = d;
    wb_ex_valid_i[k] = ex;
  endtask

  // Check the current cycle against the model, advance the model, then cross the clock edge.
  task automatic step();
    logic              full, iv, cv;
    logic [NE-1:0]     si;
    scoreboard_entry_t e;
    #1;
    full = (mq.size() == NE);
    iv   = decoded_instr_valid_i && !full && !flush_i;
    cv   = 1'b0;
    if (mq.size() > 0) cv = mq[0].valid && !flush_i;
    e = decoded_instr_i;
    e.trans_id = IDW'(mptr);
    chk("issue_vld", 256'(issue_instr_valid_o), 256'(iv));
    chk("dec_ack", 256'(decoded_instr_ack_o), 256'(iv && issue_ack_i));
    chk("issue_instr", 256'(issue_instr_o), 256'(e));
    chk("commit_vld", 256'(commit_valid_o), 256'(cv));
    if (cv) chk("commit_instr", 256'(commit_instr_o), 256'(mq[0]));
    si = '0;
    foreach (mq[i]) if (mq[i].rd != 5'd0) si[mq[i].trans_id] = 1'b1;
    chk("still_issued", 256'(fwd_o.still_issued), 256'(si));
    chk("issue_pointer", 256'(fwd_o.issue_pointer), 256'(mptr));
    foreach (mq[i]) chk("sbe", 256'(fwd_o.sbe[mq[i].trans_id]), 256'(mq[i]));
    for (int k = 0; k < NW; k++)
      chk("fwd_wb", 256'(fwd_o.wb[k]),
          256'({wb_valid_i[k], wb_ex_valid_i[k], wb_trans_id_i[k], wb_data_i[k]}));

    if (flush_i) begin
      mq.delete();
      mptr = 0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wb_valid_i[k]) begin
          foreach (mq[i]) begin
            if (mq[i].trans_id == wb_trans_id_i[k]) begin
              scoreboard_entry_t t;
              t = mq[i];
              t.valid  = 1'b1;
              t.result = wb_data_i[k];
              if (wb_ex_valid_i[k]) begin
                t.ex.valid = 1'b1;
                t.ex.tval  = wb_data_i[k];
              end
              mq[i] = t;
            end
          end
        end
      end
      if (cv && commit_ack_i) void'(mq.pop_front());
      if (iv && issue_ack_i) begin
        e.valid = e.ex.valid;
        mq.push_back(e);
        mptr = (mptr + 1) % NE;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_cycle();
    logic [IDW-1:0] t;
    logic           dup;
    idle();
    decoded_instr_i       = rand_entry(10);
    decoded_instr_valid_i = ($urandom % 10) < 7;
    issue_ack_i           = ($urandom % 10) < 7;
    commit_ack_i          = ($urandom % 10) < 6;
    flush_i               = ($urandom % 50) == 0;
    for (int k = 0; k < NW; k++) begin
      if (($urandom % 10) < 3) begin
        if (mq.size() > 0 && ($urandom % 4) != 0) t = mq[$urandom_range(0, mq.size() - 1)].trans_id;
        else t = IDW'($urandom);
        dup = 1'b0;
        for (int j = 0; j < k; j++) if (wb_valid_i[j] && wb_trans_id_i[j] == t) dup = 1'b1;
        if (!dup) put_wb(k, int'(t), $urandom, ($urandom % 8) == 0);
      end
    end
    step();
  endtask

  initial begin
    scoreboard_entry_t e;
    idle();
    #2;
    chk("rst_issue_vld", 256'(issue_instr_valid_o), 256'(0));
    chk("rst_commit_vld", 256'(commit_valid_o), 256'(0));
    chk("rst_commit_instr", 256'(commit_instr_o), 256'(0));
    chk("rst_still", 256'(fwd_o.still_issued), 256'(0));
    chk("rst_ptr", 256'(fwd_o.issue_pointer), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single issue to x5, then write-back and commit.
    idle(); e = rand_entry(0); e.rd = 5'd5; offer(e); step();
    idle(); #1;
    chk("t1_still0", 256'(fwd_o.still_issued[0]), 256'(1));
    chk("t1_ptr", 256'(fwd_o.issue_pointer), 256'(1));
    put_wb(0, 0, 32'h1234, 1'b0); #1;
    chk("t2_bypass", 256'(fwd_o.wb[0].data), 256'(32'h1234));
    step();
    idle(); #1;
    chk("t2_sbe_vld", 256'(fwd_o.sbe[0].valid), 256'(1));
    chk("t2_result", 256'(fwd_o.sbe[0].result), 256'(32'h1234));
    chk("t2_commit_vld", 256'(commit_valid_o), 256'(1));
    commit_ack_i = 1'b1; step();

    // Fill all entries, confirm issue is blocked, then free one slot.
    for (int i = 0; i < NE; i++) begin idle(); offer(rand_entry(0)); step(); end
    idle(); offer(rand_entry(0)); #1;
    chk("t3_full_blk", 256'(issue_instr_valid_o), 256'(0));
    chk("t3_full_ack", 256'(decoded_instr_ack_o), 256'(0));
    step();
    idle(); put_wb(2, int'(mq[0].trans_id), $urandom, 1'b0); step();
    idle(); offer(rand_entry(0)); commit_ack_i = 1'b1; #1;
    chk("t3_no_bypass", 256'(issue_instr_valid_o), 256'(0));
    chk("t3_commit_vld", 256'(commit_valid_o), 256'(1));
    step();
    idle(); offer(rand_entry(0)); #1;
    chk("t3_reopen", 256'(issue_instr_valid_o), 256'(1));
    chk("t3_wrap_tag", 256'(issue_instr_o.trans_id), 256'(1));
    step();

    // Flush colliding with ack, write-back and a committable head.
    idle(); put_wb(0, int'(mq[0].trans_id), $urandom, 1'b0); step();
    idle(); offer(rand_entry(0)); put_wb(1, int'(mq[1].trans_id), $urandom, 1'b0);
    commit_ack_i = 1'b1; flush_i = 1'b1; #1;
    chk("t6_commit_gated", 256'(commit_valid_o), 256'(0));
    chk("t6_issue_gated", 256'(issue_instr_valid_o), 256'(0));
    step();
    idle(); #1;
    chk("t6_still", 256'(fwd_o.still_issued), 256'(0));
    chk("t6_ptr", 256'(fwd_o.issue_pointer), 256'(0));

    // Out-of-order write-back, in-order retire.
    for (int i = 0; i < 3; i++) begin idle(); offer(rand_entry(0)); step(); end
    idle(); put_wb(1, 2, $urandom, 1'b0); put_wb(3, 0, $urandom, 1'b0); step();
    idle(); commit_ack_i = 1'b1; #1;
    chk("t4_c0", 256'(commit_instr_o.trans_id), 256'(0));
    step();
    idle(); commit_ack_i = 1'b1; #1;
    chk("t4_wait1", 256'(commit_valid_o), 256'(0));
    step();
    idle(); put_wb(2, 1, $urandom, 1'b0); step();
    idle(); commit_ack_i = 1'b1; #1;
    chk("t4_c1", 256'(commit_instr_o.trans_id), 256'(1));
    step();
    idle(); commit_ack_i = 1'b1; #1;
    chk("t4_c2", 256'(commit_instr_o.trans_id), 256'(2));
    step();

    // Write-back exception, then a front-end exception that needs no write-back.
    idle(); offer(rand_entry(0)); step();
    idle(); put_wb(0, 3, 32'hdeadbeef, 1'b1); step();
    idle(); #1;
    chk("t5_commit_vld", 256'(commit_valid_o), 256'(1));
    chk("t5_ex_vld", 256'(commit_instr_o.ex.valid), 256'(1));
    chk("t5_tval", 256'(commit_instr_o.ex.tval), 256'(32'hdeadbeef));
    commit_ack_i = 1'b1; step();
    idle(); offer(rand_entry(100)); step();
    idle(); #1;
    chk("t5_fe_ex_vld", 256'(commit_valid_o), 256'(1));
    chk("t5_fe_ex", 256'(commit_instr_o.ex.valid), 256'(1));
    commit_ack_i = 1'b1; step();

    for (int c = 0; c < 3000; c++) rand_cycle();

    // Asynchronous reset in the middle of a cycle with work in flight.
    idle();
    if (mq.size() < NE) begin e = rand_entry(0); e.rd = 5'd7; offer(e); step(); idle(); end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_still", 256'(fwd_o.still_issued), 256'(0));
    chk("arst_ptr", 256'(fwd_o.issue_pointer), 256'(0));
    chk("arst_commit_vld", 256'(commit_valid_o), 256'(0));
    mq.delete();
    mptr = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < 50; c++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
